// File: rtl/mac_pkg.sv
// Shared types and constants for the multiply-accumulate datapath.
package mac_pkg;

    localparam int unsigned MUL_W  = 4;
    localparam int unsigned PROD_W = 2 * MUL_W;
    localparam int unsigned OP_MAX = (1 << MUL_W) - 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } mac_state_t;

endpackage

// File: rtl/am_structural.sv
// 4x4 unsigned array multiplier: AND-gate partial products reduced row by row
// through ripple-carry full-adder chains. Purely combinational.
module am_structural
    import mac_pkg::*;
(
    input  logic [MUL_W-1:0]  i_a,
    input  logic [MUL_W-1:0]  i_b,
    output logic [PROD_W-1:0] o_prod_c
);

    logic [MUL_W-1:0][MUL_W-1:0] w_pp;
    logic [MUL_W-1:0][MUL_W:0]   w_row;
    logic [MUL_W:0]              w_cy;

    // Partial products, then each row adds the previous row's upper bits.
    always_comb begin
        w_pp  = '0;
        w_row = '0;
        w_cy  = '0;
        for (int r = 0; r < MUL_W; r++) begin
            w_pp[r] = i_a & {MUL_W{i_b[r]}};
        end
        w_row[0] = {1'b0, w_pp[0]};
        for (int r = 1; r < MUL_W; r++) begin
            w_cy = '0;
            for (int j = 0; j < MUL_W; j++) begin
                w_row[r][j] = w_row[r-1][j+1] ^ w_pp[r][j] ^ w_cy[j];
                w_cy[j+1]   = (w_row[r-1][j+1] & w_pp[r][j])
                            | (w_cy[j] & (w_row[r-1][j+1] ^ w_pp[r][j]));
            end
            w_row[r][MUL_W] = w_cy[MUL_W];
        end
    end

    // Low product bits fall out of each row's LSB; the top row gives the rest.
    always_comb begin
        o_prod_c = '0;
        for (int r = 0; r < MUL_W; r++) begin
            o_prod_c[r] = w_row[r][0];
        end
        o_prod_c[PROD_W-1:MUL_W] = w_row[MUL_W-1][MUL_W:1];
    end

endmodule

// File: rtl/mac_accumulator.sv
// Dot-product engine: accepts LEN operand pairs over valid/ready, registers
// each product, sums them and offers the result over valid/ready.
// Build option MAC_SATURATE_EN: clamp the accumulator at its maximum on
// overflow instead of wrapping.
module mac_accumulator
    import mac_pkg::*;
#(
    parameter int unsigned OP_W  = 4,
    parameter int unsigned LEN   = 8,
    parameter int unsigned ACC_W = 12
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  a,
    input  logic [OP_W-1:0]  b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic             out_ovf,
    output logic             busy
);

    localparam int unsigned      CNT_W   = $clog2(LEN + 1);
    localparam int unsigned      SUM_W   = ACC_W + 1;
    localparam logic [CNT_W-1:0] LEN_C   = CNT_W'(LEN);
    localparam logic [ACC_W-1:0] ACC_MAX = '1;

    mac_state_t        r_state;
    mac_state_t        w_state_nxt;
    logic [CNT_W-1:0]  r_acc_cnt;
    logic [CNT_W-1:0]  w_acc_cnt_nxt;
    logic [CNT_W-1:0]  r_sum_cnt;
    logic [CNT_W-1:0]  w_sum_cnt_nxt;
    logic [PROD_W-1:0] r_p_q;
    logic              r_p_v;
    logic [ACC_W-1:0]  r_acc;
    logic [ACC_W-1:0]  w_acc_nxt;
    logic              r_ovf;
    logic              w_ovf_nxt;
    logic              r_in_ready;
    logic              r_out_valid;
    logic              r_busy;
    logic [PROD_W-1:0] w_prod;
    logic [SUM_W-1:0]  w_sum;
    logic              w_accept;

    am_structural u_mul (
        .i_a      (a),
        .i_b      (b),
        .o_prod_c (w_prod)
    );

    // in_ready is only ever high in ACCUM, so this is the whole accept rule.
    assign w_accept = in_valid & r_in_ready;
    // One bit wider than the accumulator so the carry-out is visible.
    assign w_sum    = {1'b0, r_acc} + SUM_W'(r_p_q);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state plus next counter and accumulator values.
    always_comb begin
        w_state_nxt   = r_state;
        w_acc_cnt_nxt = r_acc_cnt;
        w_sum_cnt_nxt = r_sum_cnt;
        w_acc_nxt     = r_acc;
        w_ovf_nxt     = r_ovf;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_acc_cnt_nxt = '0;
                    w_sum_cnt_nxt = '0;
                    w_acc_nxt     = '0;
                    w_ovf_nxt     = 1'b0;
                    w_state_nxt   = ACCUM;
                end
            end
            ACCUM: begin
                if (w_accept) begin
                    w_acc_cnt_nxt = r_acc_cnt + CNT_W'(1);
                end
                if (r_p_v) begin
                    w_sum_cnt_nxt = r_sum_cnt + CNT_W'(1);
                    w_ovf_nxt     = r_ovf | w_sum[ACC_W];
`ifdef MAC_SATURATE_EN
                    w_acc_nxt     = (w_sum[ACC_W] | r_ovf) ? ACC_MAX : w_sum[ACC_W-1:0];
`else
                    w_acc_nxt     = w_sum[ACC_W-1:0];
`endif
                    if (w_sum_cnt_nxt == LEN_C) begin
                        w_state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                if (r_out_valid && out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Beat counters, accumulator and sticky overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc_cnt <= '0;
            r_sum_cnt <= '0;
            r_acc     <= '0;
            r_ovf     <= 1'b0;
        end else begin
            r_acc_cnt <= w_acc_cnt_nxt;
            r_sum_cnt <= w_sum_cnt_nxt;
            r_acc     <= w_acc_nxt;
            r_ovf     <= w_ovf_nxt;
        end
    end

    // Product pipeline stage: capture a*b on every accepted beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p_q <= '0;
            r_p_v <= 1'b0;
        end else begin
            r_p_v <= w_accept;
            if (w_accept) begin
                r_p_q <= w_prod;
            end
        end
    end

    // Registered handshake and status outputs; out_valid trails DONE entry by one edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_in_ready  <= (w_state_nxt == ACCUM) && (w_acc_cnt_nxt < LEN_C);
            r_out_valid <= (r_state == DONE) && (w_state_nxt == DONE);
            r_busy      <= (w_state_nxt != IDLE);
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_acc   = r_acc;
    assign out_ovf   = r_ovf;
    assign busy      = r_busy;

endmodule

// File: tb/tb_mac_accumulator.sv
// Scoreboard bench for mac_accumulator: a default instance (ACC_W=12) and a
// narrow instance (ACC_W=10) share stimulus; expected results come from the
// plain arithmetic total of each operand list.
module tb_mac_accumulator;
    import mac_pkg::*;

    localparam int unsigned LEN     = 8;
    localparam int unsigned ACC_W   = 12;
    localparam int unsigned ACC_W_N = 10;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start;
    logic               in_valid;
    logic [3:0]         a;
    logic [3:0]         b;
    logic               out_ready = 1'b1;
    logic               in_ready,  in_ready_n;
    logic               out_valid, out_valid_n;
    logic               out_ovf,   out_ovf_n;
    logic               busy,      busy_n;
    logic [ACC_W-1:0]   out_acc;
    logic [ACC_W_N-1:0] out_acc_n;

    typedef struct {
        int unsigned acc_w;
        bit          ovf_w;
        int unsigned acc_n;
        bit          ovf_n;
    } exp_t;

    exp_t       sb[$];
    exp_t       exp_last;
    exp_t       m_e;
    logic [3:0] va[$];
    logic [3:0] vb[$];
    int         n_vec = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         last_acc_edge = 0;
    bit         prev_ov = 1'b0;
    bit         rdy_rand = 1'b0;
    bit         rdy_force = 1'b1;

    mac_accumulator #(.OP_W(4), .LEN(LEN), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_ready(in_ready), .a(a), .b(b), .out_valid(out_valid),
        .out_ready(out_ready), .out_acc(out_acc), .out_ovf(out_ovf), .busy(busy)
    );

    mac_accumulator #(.OP_W(4), .LEN(LEN), .ACC_W(ACC_W_N)) dut_n (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_ready(in_ready_n), .a(a), .b(b), .out_valid(out_valid_n),
        .out_ready(out_ready), .out_acc(out_acc_n), .out_ovf(out_ovf_n), .busy(busy_n)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Downstream ready: random or forced, changed well clear of the edges.
    always @(posedge clk) begin
        #2;
        out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_force;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Unsigned total of the list, reduced to a w-bit accumulator.
    function automatic void model(input int unsigned total, input int unsigned w,
                                  output int unsigned acc, output bit ovf);
        int unsigned lim;
        lim = (1 << w) - 1;
        ovf = (total > lim);
`ifdef MAC_SATURATE_EN
        acc = ovf ? lim : total;
`else
        acc = total % (lim + 1);
`endif
    endfunction

    function automatic exp_t predict();
        exp_t        e;
        int unsigned total = 0;
        foreach (va[i]) total += int'(va[i]) * int'(vb[i]);
        model(total, ACC_W,   e.acc_w, e.ovf_w);
        model(total, ACC_W_N, e.acc_n, e.ovf_n);
        return e;
    endfunction

    // Monitor: latency of out_valid and scoreboard pop on each output handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_ov = 1'b0;
        end else begin
            if (in_valid && in_ready) last_acc_edge = cyc + 1;
            if (out_valid && !prev_ov) chk("latency_edge", cyc, last_acc_edge + 2);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_result: got acc %0d, expected no result", out_acc);
                end else begin
                    m_e = sb.pop_front();
                    chk("acc_w12",    out_acc,     m_e.acc_w);
                    chk("ovf_w12",    out_ovf,     m_e.ovf_w);
                    chk("acc_w10",    out_acc_n,   m_e.acc_n);
                    chk("ovf_w10",    out_ovf_n,   m_e.ovf_n);
                    chk("valid_w10",  out_valid_n, 1);
                end
            end
            prev_ov = out_valid;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_beat(input logic [3:0] ai, input logic [3:0] bi, input bit st);
        int budget = 0;
        in_valid = 1'b1;
        a        = ai;
        b        = bi;
        start    = st;
        while (!in_ready && budget < 50) begin
            tick();
            budget++;
        end
        if (!in_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL beat_accept_timeout: in_ready %0d, expected 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        start    = 1'b0;
        a        = 4'($urandom);
        b        = 4'($urandom);
    endtask

    task automatic run_txn(input int gap_min, input int gap_max, input bit rnd_start);
        exp_last = predict();
        sb.push_back(exp_last);
        do_start();
        chk("start_busy",     busy,     1);
        chk("start_in_ready", in_ready, 1);
        foreach (va[i]) begin
            send_beat(va[i], vb[i], rnd_start && ($urandom_range(0, 3) == 0));
            repeat ($urandom_range(gap_min, gap_max)) tick();
        end
    endtask

    task automatic wait_drain();
        int budget = 0;
        while (sb.size() != 0 && budget < 200) begin
            @(negedge clk);
            #1;
            budget++;
        end
        if (sb.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: %0d results pending, expected 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
        chk("idle_out_valid", out_valid, 0);
        chk("idle_busy",      busy,      0);
        chk("idle_in_ready",  in_ready,  0);
    endtask

    task automatic fill(input logic [3:0] fa, input logic [3:0] fb);
        va.delete();
        vb.delete();
        repeat (LEN) begin
            va.push_back(fa);
            vb.push_back(fb);
        end
    endtask

    task automatic fill_rand();
        va.delete();
        vb.delete();
        repeat (LEN) begin
            va.push_back(4'($urandom));
            vb.push_back(4'($urandom));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time exceeded, expected completion");
        $fatal(1);
    end

    initial begin
        int budget;
        logic [3:0] la [8] = '{4'd1, 4'd3, 4'd5, 4'd7, 4'd0, 4'd15, 4'd2, 4'd10};
        logic [3:0] lb [8] = '{4'd2, 4'd4, 4'd6, 4'd8, 4'd9, 4'd1,  4'd2, 4'd10};

        rst_n    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;

        // Reset held with random inputs: everything stays cleared.
        repeat (3) begin
            @(negedge clk);
            start    = 1'($urandom);
            in_valid = 1'($urandom);
            a        = 4'($urandom);
            b        = 4'($urandom);
            #1;
            chk("rst_in_ready",  in_ready,   0);
            chk("rst_out_valid", out_valid,  0);
            chk("rst_out_acc",   out_acc,    0);
            chk("rst_out_ovf",   out_ovf,    0);
            chk("rst_busy",      busy,       0);
            chk("rst_acc_w10",   out_acc_n,  0);
            chk("rst_ready_w10", in_ready_n, 0);
            chk("rst_busy_w10",  busy_n,     0);
        end
        start    = 1'b0;
        in_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // Back-to-back maximum operands.
        fill(4'(OP_MAX), 4'(OP_MAX));
        rdy_force = 1'b1;
        run_txn(0, 0, 1'b0);
        wait_drain();

        // Gapped beats, result held while downstream stalls, start ignored in DONE.
        va.delete();
        vb.delete();
        foreach (la[i]) begin
            va.push_back(la[i]);
            vb.push_back(lb[i]);
        end
        rdy_force = 1'b0;
        run_txn(2, 2, 1'b0);
        budget = 0;
        while (!out_valid && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            start = (k == 1);
            chk("hold_out_valid", out_valid, 1);
            chk("hold_out_acc",   out_acc,   exp_last.acc_w);
            chk("hold_out_ovf",   out_ovf,   exp_last.ovf_w);
        end
        start     = 1'b0;
        rdy_force = 1'b1;
        wait_drain();

        // Asynchronous reset after three accepted beats discards the run.
        tick();
        fill(4'd5, 4'd5);
        do_start();
        for (int i = 0; i < 3; i++) send_beat(va[i], vb[i], 1'b0);
        rst_n = 1'b0;
        #1;
        chk("arst_in_ready",  in_ready,  0);
        chk("arst_out_valid", out_valid, 0);
        chk("arst_out_acc",   out_acc,   0);
        chk("arst_out_ovf",   out_ovf,   0);
        chk("arst_busy",      busy,      0);
        chk("arst_acc_w10",   out_acc_n, 0);
        #2;
        tick();
        rst_n = 1'b1;
        tick();
        fill(4'd1, 4'd1);
        run_txn(0, 0, 1'b0);
        wait_drain();

        // in_valid in IDLE without start is ignored.
        tick();
        in_valid = 1'b1;
        a        = 4'd15;
        b        = 4'd15;
        repeat (4) begin
            tick();
            chk("idle_no_ready", in_ready, 0);
            chk("idle_acc_kept", out_acc,  exp_last.acc_w);
            chk("idle_no_busy",  busy,     0);
        end
        in_valid = 1'b0;
        tick();
        fill_rand();
        run_txn(0, 1, 1'b1);
        wait_drain();

        // Random operands, gaps, stray starts and downstream stalls.
        rdy_rand = 1'b1;
        repeat (20) begin
            tick();
            fill_rand();
            run_txn(0, 2, 1'b1);
            wait_drain();
        end
        rdy_rand = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
